hazard_ctrl: RTL

Pipeline hazard controller for the 16-bit, 8-register core. It drives the write-enable and flush (synchronous clear) inputs of the PC, IF/ID and ID/EX pipeline registers. It consumes the ID/EX register's outputs (rd, MemRead, RegWrite) plus decode-stage source indices, the EX branch outcome and the data-memory busy flag. It produces load-use bubbles, branch flushes and whole-front-end freezes.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard sources in, pipeline-register
// write/flush controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_flush;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_mem_read, ex_reg_write, branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_mem_read, ex_reg_write, branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory freezes.
// Optional saturating stall/flush counters are enabled with HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic          CLK,
  input logic          Reset,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, BR_FLUSH} state_e;

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fc_q, fc_d;
  logic       load_use;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;

  // R0 is hardwired zero, so a load targeting it never needs a bubble.
  assign load_use = hz.ex_mem_read & hz.ex_reg_write &
                    (hz.ex_rd != {REG_AW{1'b0}}) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    fc_q    <= fc_d;
  end

  always_comb begin
    state_d      = state_q;
    fc_d         = fc_q;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    idex_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    if (Reset) begin
      state_d      = RUN;
      fc_d         = 3'd0;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_write_o = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (hz.mem_busy) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_write_o = 1'b0;
      state_d      = MEM_WAIT;
    end else if (state_q == BR_FLUSH || (state_q == MEM_WAIT && fc_q != 3'd0)) begin
      // A freeze that interrupted a flush resumes flushing straight away:
      // the frozen slots still hold wrong-path instructions.
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      fc_d         = fc_q - 3'd1;
      if (fc_q <= 3'd1) state_d = RUN;
      else              state_d = BR_FLUSH;
    end else if (hz.branch_taken) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_d      = RUN;
      if (FLUSH_CYCLES > 1) begin
        state_d = BR_FLUSH;
        fc_d    = FC_INIT;
      end
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
      state_d      = RUN;
    end else begin
      state_d = RUN;
    end
  end

  assign hz.pc_write   = pc_write_o;
  assign hz.ifid_write = ifid_write_o;
  assign hz.ifid_flush = ifid_flush_o;
  assign hz.idex_write = idex_write_o;
  assign hz.idex_flush = idex_flush_o;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_evt, flush_evt;

  // Outside reset, pc_write is low exactly on freeze and load-use cycles.
  assign stall_evt = ~Reset & ~pc_write_o;
  assign flush_evt = ~Reset & ifid_flush_o;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
      if (flush_evt && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_cycles = {CNT_W{1'b0}};
`endif
endmodule
